// File: rtl/apb_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | apb_pkg                                                               |
// | Shared APB widths, slave-select bit and requester state encoding.     |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package apb_pkg;

  localparam int APB_ADDR_W  = 7;
  localparam int APB_DATA_W  = 8;
  localparam int APB_SEL_BIT = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

endpackage
`default_nettype wire

// File: rtl/apb_wait_timer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | apb_wait_timer                                                        |
// | Counts consecutive PREADY-low ACCESS cycles and flags an abort on the |
// | TIMEOUT_CYCLES-th one.                                                |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module apb_wait_timer #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_access,
  input  logic i_pready,
  output logic o_abort
);

  localparam int                CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  c_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_stall;

  assign w_stall = i_access & ~i_pready;
  // Abort is decided on the edge that would otherwise be the next stall.
  assign o_abort = w_stall & (r_cnt == c_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (w_stall && !o_abort) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/apb_master.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | apb_master                                                            |
// | valid/ready command to APB requester for two slaves (PADDR[6] select).|
// | Optional stall abort: define APB_MASTER_TIMEOUT_EN.                   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module apb_master
  import apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [APB_ADDR_W-1:0] req_addr,
  input  logic [APB_DATA_W-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [APB_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  PSELECT1,
  output logic                  PSELECT2,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [APB_ADDR_W-1:0] PADDR,
  output logic [APB_DATA_W-1:0] PWDATA,
  input  logic [APB_DATA_W-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  apb_state_t            r_state;
  logic                  r_psel1;
  logic                  r_psel2;
  logic                  r_penable;
  logic                  r_pwrite;
  logic [APB_ADDR_W-1:0] r_paddr;
  logic [APB_DATA_W-1:0] r_pwdata;
  logic                  r_rsp_valid;
  logic [APB_DATA_W-1:0] r_rsp_rdata;
  logic                  r_rsp_err;
  logic                  w_abort;

`ifdef APB_MASTER_TIMEOUT_EN
  apb_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk      (PCLK),
    .rst_n    (PRESET),
    .i_clear  (r_state == SETUP),
    .i_access (r_state == ACCESS),
    .i_pready (PREADY),
    .o_abort  (w_abort)
  );
`else
  logic w_unused_timeout;
  assign w_unused_timeout = TIMEOUT_CYCLES[0];
  assign w_abort          = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      r_state     <= IDLE;
      r_psel1     <= 1'b0;
      r_psel2     <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_pwrite  <= req_write;
            r_paddr   <= req_addr;
            r_pwdata  <= req_wdata;
            r_psel1   <= ~req_addr[APB_SEL_BIT];
            r_psel2   <= req_addr[APB_SEL_BIT];
            r_penable <= 1'b0;
            r_state   <= SETUP;
          end
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ACCESS;
        end
        ACCESS: begin
          // A completing PREADY takes priority over a same-edge abort.
          if (PREADY) begin
            r_psel1     <= 1'b0;
            r_psel2     <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= PSLVERR;
            r_rsp_rdata <= r_pwrite ? '0 : PRDATA;
            r_state     <= IDLE;
          end else if (w_abort) begin
            r_psel1     <= 1'b0;
            r_psel2     <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= '0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_psel1   <= 1'b0;
          r_psel2   <= 1'b0;
          r_penable <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign PSELECT1  = r_psel1;
  assign PSELECT2  = r_psel2;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;

endmodule
`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_apb_master                                                         |
// | Directed self-checking bench for apb_master (TIMEOUT_CYCLES = 4).     |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_apb_master;

  logic       PCLK;
  logic       PRESET;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [6:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       PSELECT1;
  logic       PSELECT2;
  logic       PENABLE;
  logic       PWRITE;
  logic [6:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic       PSLVERR;

  int n_cmp = 0;
  int n_err = 0;

  apb_master #(
    .TIMEOUT_CYCLES (4)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PSELECT1  (PSELECT1),
    .PSELECT2  (PSELECT2),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic wr, input logic [6:0] a, input logic [7:0] d);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
  endtask

  initial begin
    int seen;
    PRESET    = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    PRDATA    = '0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;

    // Reset values
    #2 PRESET = 1'b0;
    #1;
    chk("rst_req_ready", {7'd0, req_ready}, 8'h01);
    chk("rst_rsp_valid", {7'd0, rsp_valid}, 8'h00);
    chk("rst_psel",      {6'd0, PSELECT2, PSELECT1}, 8'h00);
    chk("rst_penable",   {7'd0, PENABLE}, 8'h00);
    chk("rst_paddr",     {1'b0, PADDR}, 8'h00);
    @(negedge PCLK);
    @(negedge PCLK);
    PRESET = 1'b1;
    tick;

    // Write 0x15 <- 0xA5 to slave 1, no wait states
    cmd(1'b1, 7'h15, 8'hA5);
    PREADY = 1'b1;
    tick;
    req_valid = 1'b0;
    chk("w1_setup_psel",   {6'd0, PSELECT2, PSELECT1}, 8'h01);
    chk("w1_setup_pen",    {7'd0, PENABLE}, 8'h00);
    chk("w1_setup_ready",  {7'd0, req_ready}, 8'h00);
    chk("w1_paddr",        {1'b0, PADDR}, 8'h15);
    chk("w1_pwdata",       PWDATA, 8'hA5);
    chk("w1_pwrite",       {7'd0, PWRITE}, 8'h01);
    tick;
    chk("w1_access_psel",  {6'd0, PSELECT2, PSELECT1}, 8'h01);
    chk("w1_access_pen",   {7'd0, PENABLE}, 8'h01);
    chk("w1_access_rspv",  {7'd0, rsp_valid}, 8'h00);
    tick;
    chk("w1_rsp_valid",    {7'd0, rsp_valid}, 8'h01);
    chk("w1_rsp_err",      {7'd0, rsp_err}, 8'h00);
    chk("w1_rsp_rdata",    rsp_rdata, 8'h00);
    chk("w1_idle_psel",    {6'd0, PSELECT2, PSELECT1, PENABLE}, 8'h00);
    chk("w1_idle_paddr",   {1'b0, PADDR}, 8'h15);
    tick;
    chk("w1_rsp_pulse",    {7'd0, rsp_valid}, 8'h00);

    // Read 0x55 from slave 2 with two wait states
    cmd(1'b0, 7'h55, 8'h00);
    PREADY = 1'b0;
    tick;
    req_valid = 1'b0;
    chk("r2_setup_psel",   {6'd0, PSELECT2, PSELECT1}, 8'h02);
    tick;
    chk("r2_acc1_pen",     {7'd0, PENABLE}, 8'h01);
    tick;
    chk("r2_acc2_pen",     {7'd0, PENABLE}, 8'h01);
    chk("r2_acc2_rspv",    {7'd0, rsp_valid}, 8'h00);
    tick;
    chk("r2_acc3_psel",    {6'd0, PSELECT2, PSELECT1}, 8'h02);
    PREADY = 1'b1;
    PRDATA = 8'h3C;
    tick;
    chk("r2_rsp_valid",    {7'd0, rsp_valid}, 8'h01);
    chk("r2_rsp_rdata",    rsp_rdata, 8'h3C);
    chk("r2_rsp_err",      {7'd0, rsp_err}, 8'h00);

    // Slave error on a write, then a clean read
    cmd(1'b1, 7'h20, 8'h11);
    PSLVERR = 1'b1;
    tick;
    req_valid = 1'b0;
    tick;
    tick;
    chk("err_rsp_valid",   {7'd0, rsp_valid}, 8'h01);
    chk("err_rsp_err",     {7'd0, rsp_err}, 8'h01);
    PSLVERR = 1'b0;
    PRDATA  = 8'h5A;
    cmd(1'b0, 7'h7F, 8'h00);
    tick;
    req_valid = 1'b0;
    chk("err_hold",        {7'd0, rsp_err}, 8'h01);
    tick;
    tick;
    chk("clean_rsp_err",   {7'd0, rsp_err}, 8'h00);
    chk("clean_rsp_rdata", rsp_rdata, 8'h5A);

    // Back-to-back with req_valid held high
    cmd(1'b1, 7'h02, 8'h77);
    tick;
    cmd(1'b0, 7'h43, 8'h00);
    PRDATA = 8'h99;
    chk("b2b_setup_ready", {7'd0, req_ready}, 8'h00);
    tick;
    chk("b2b_acc_ready",   {7'd0, req_ready}, 8'h00);
    chk("b2b_acc_paddr",   {1'b0, PADDR}, 8'h02);
    tick;
    chk("b2b_a_rspv",      {7'd0, rsp_valid}, 8'h01);
    chk("b2b_a_ready",     {7'd0, req_ready}, 8'h01);
    chk("b2b_a_rdata",     rsp_rdata, 8'h00);
    tick;
    req_valid = 1'b0;
    chk("b2b_b_paddr",     {1'b0, PADDR}, 8'h43);
    chk("b2b_b_psel",      {6'd0, PSELECT2, PSELECT1}, 8'h02);
    chk("b2b_b_rspv0",     {7'd0, rsp_valid}, 8'h00);
    tick;
    tick;
    chk("b2b_b_rspv",      {7'd0, rsp_valid}, 8'h01);
    chk("b2b_b_rdata",     rsp_rdata, 8'h99);

    // Stalled read: abort with the timeout feature, else wait forever
    cmd(1'b0, 7'h10, 8'h00);
    PREADY = 1'b0;
    tick;
    req_valid = 1'b0;
    tick;
`ifdef APB_MASTER_TIMEOUT_EN
    tick;
    tick;
    tick;
    chk("to_acc4_pen",     {7'd0, PENABLE}, 8'h01);
    chk("to_acc4_rspv",    {7'd0, rsp_valid}, 8'h00);
    tick;
    chk("to_rsp_valid",    {7'd0, rsp_valid}, 8'h01);
    chk("to_rsp_err",      {7'd0, rsp_err}, 8'h01);
    chk("to_rsp_rdata",    rsp_rdata, 8'h00);
    chk("to_bus_idle",     {5'd0, PSELECT2, PSELECT1, PENABLE}, 8'h00);
    chk("to_ready",        {7'd0, req_ready}, 8'h01);
`else
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      tick;
      if (rsp_valid) seen++;
    end
    chk("nto_no_rsp",      8'(seen), 8'h00);
    chk("nto_still_acc",   {5'd0, PSELECT2, PSELECT1, PENABLE}, 8'h03);
    chk("nto_ready",       {7'd0, req_ready}, 8'h00);
    PREADY = 1'b1;
    PRDATA = 8'hE1;
    tick;
    chk("nto_rsp_rdata",   rsp_rdata, 8'hE1);
    chk("nto_rsp_err",     {7'd0, rsp_err}, 8'h00);
`endif
    tick;

    // Reset in the middle of an ACCESS phase
    cmd(1'b1, 7'h30, 8'hC3);
    PREADY = 1'b0;
    tick;
    req_valid = 1'b0;
    tick;
    chk("mr_in_access",    {7'd0, PENABLE}, 8'h01);
    #2 PRESET = 1'b0;
    #1;
    chk("mr_ready",        {7'd0, req_ready}, 8'h01);
    chk("mr_bus",          {4'd0, PWRITE, PSELECT2, PSELECT1, PENABLE}, 8'h00);
    chk("mr_paddr",        {1'b0, PADDR}, 8'h00);
    chk("mr_pwdata",       PWDATA, 8'h00);
    chk("mr_rsp",          {6'd0, rsp_err, rsp_valid}, 8'h00);
    tick;
    chk("mr_no_rspv",      {7'd0, rsp_valid}, 8'h00);
    @(negedge PCLK);
    PRESET = 1'b1;
    tick;
    cmd(1'b0, 7'h01, 8'h00);
    PREADY = 1'b1;
    PRDATA = 8'h42;
    tick;
    req_valid = 1'b0;
    chk("mr_rd_psel",      {6'd0, PSELECT2, PSELECT1}, 8'h01);
    tick;
    tick;
    chk("mr_rd_rspv",      {7'd0, rsp_valid}, 8'h01);
    chk("mr_rd_rdata",     rsp_rdata, 8'h42);
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb_master.md
# apb_master

APB requester that turns a simple valid/ready command interface into APB transfers toward the two memory-mapped APB slaves. It runs the IDLE/SETUP/ACCESS sequence and decodes the slave select from PADDR[6]. It honours PREADY wait states, returns read data and PSLVERR status as a one-cycle response pulse, and can optionally abort transfers that stall. It is the initiator end of the bus that the Slave1/Slave2 responders serve.

## Interface
- TIMEOUT_CYCLES, 15: maximum consecutive ACCESS cycles with PREADY low before an abort. Used only when the timeout feature is compiled in; must be ≥1.

- PCLK  in  1  bus clock; all state changes on the rising edge.
- PRESET  in  1  reset, asynchronous, active-low.
- req_valid  in  1  command present.
- req_ready  out  1  master can accept a command (IDLE only).
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  7  target address; bit 6 selects the slave.
- req_wdata  in  8  write data.
- rsp_valid  out  1  one-cycle pulse: transfer finished.
- rsp_rdata  out  8  read data; 0x00 for writes and aborts.
- rsp_err  out  1  PSLVERR captured at completion, or 1 on timeout abort.
- PSELECT1  out  1  select for slave 1 (PADDR[6]=0).
- PSELECT2  out  1  select for slave 2 (PADDR[6]=1).
- PENABLE  out  1  APB access phase.
- PWRITE  out  1  transfer direction.
- PADDR  out  7  transfer address.
- PWDATA  out  8  write data.
- PRDATA  in  8  read data from the selected slave.
- PREADY  in  1  slave ready; sampled only in ACCESS.
- PSLVERR  in  1  slave error; sampled only with PREADY in ACCESS.

## Operation
- Reset values: all outputs 0, except req_ready = 1. State = IDLE.
- Reset assertion at any time, including mid-transfer, forces the reset values immediately. No rsp_valid is issued for the killed transfer.
- **IDLE:** req_ready = 1. On a PCLK edge with req_valid = 1, the master registers req_write/req_addr/req_wdata into PWRITE/PADDR/PWDATA and moves to SETUP.
- **SETUP:** exactly one cycle. The decoded PSELECTx = 1, PENABLE = 0, req_ready = 0. Next state is ACCESS.
- **ACCESS:** PSELECTx = 1, PENABLE = 1.
  - PREADY = 0 at the edge: stay in ACCESS.
  - PREADY = 1 at the edge: go to IDLE.
    - rsp_valid = 1 for the following cycle.
    - rsp_err = PSLVERR.
    - rsp_rdata = PRDATA for reads, 0x00 for writes.
- PADDR, PWRITE and PWDATA are stable from SETUP through the end of ACCESS. They hold their last value in IDLE and do not toggle there.
- Exactly one PSELECTx is high in SETUP/ACCESS. Both are low in IDLE.
- rsp_rdata and rsp_err hold their value until the next response.
- A command accepted in the same IDLE cycle that shows rsp_valid is legal and is processed normally.

## Timing
- Accept on edge 0 → SETUP in cycle 1 → ACCESS in cycle 2.
- Zero wait states: rsp_valid in cycle 3, so minimum spacing is 3 cycles per transfer.
- Each PREADY-low cycle in ACCESS adds exactly one cycle of latency.
- req_ready is combinational from state only; it never depends on req_valid.

## Configuration
- APB_MASTER_TIMEOUT_EN, when defined:
  - A wait counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to ACCESS and increments on every ACCESS cycle with PREADY = 0.
  - If the TIMEOUT_CYCLES-th consecutive ACCESS cycle still has PREADY = 0, the master aborts at that edge:
    - goes to IDLE and drops PSELECTx/PENABLE;
    - issues rsp_valid with rsp_err = 1 and rsp_rdata = 0x00.
  - A PREADY = 1 on that same edge wins: normal completion, no abort.
- APB_MASTER_TIMEOUT_EN not defined: no counter exists, ACCESS waits indefinitely, and TIMEOUT_CYCLES is unused.

## Structure
- Shared package apb_pkg holds:
  - APB_ADDR_W = 7, APB_DATA_W = 8, APB_SEL_BIT = 6;
  - the state enum apb_state_t {IDLE, SETUP, ACCESS}.
- Optional sub-module apb_wait_timer (counter plus abort flag) is instantiated only under APB_MASTER_TIMEOUT_EN. Everything else is flat in apb_master.

## Test plan
- **Write, slave 1:** write 0x15 ← 0xA5, PREADY = 1 immediately → PSELECT1 high for 2 cycles, PENABLE high for 1 cycle, PADDR = 0x15, PWDATA = 0xA5; rsp_valid in cycle 3 with rsp_err = 0 and rsp_rdata = 0x00.
- **Read, slave 2 with wait states:** read 0x55, slave returns PRDATA = 0x3C after 2 wait states → PSELECT2 high, PSELECT1 low, ACCESS lasts 3 cycles, rsp_rdata = 0x3C.
- **Slave error:** write with PSLVERR = 1 alongside PREADY = 1 → rsp_err = 1 for that response; a following clean read returns rsp_err = 0.
- **Timeout:**
  - With APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES = 4, PREADY held 0 → abort after 4 ACCESS cycles, rsp_err = 1, rsp_rdata = 0x00, bus idle.
  - Without the macro → still in ACCESS after 100 cycles.
- **Reset mid-transfer:** assert PRESET low during ACCESS → all outputs 0 and req_ready = 1 without waiting for a clock, no rsp_valid. After release, a read of 0x01 completes normally.
- **Back-to-back:** req_valid held high with two commands → req_ready low during SETUP/ACCESS; the second command is accepted in the IDLE cycle showing rsp_valid of the first, giving 3-cycle spacing.
